// File: rtl/nv_fifo_ctrl_19x32.sv
// nv_fifo_ctrl_19x32
//   Valid/ready FIFO controller wrapped around a 19x32 RAM that has a
//   two-stage registered read: ra is captured on ram_re, then the data is
//   captured into the RAM output register on ram_ore. A 3-entry output
//   buffer absorbs the read loop so the FIFO streams one item per cycle
//   under backpressure.
//
//   Ports
//     nvdla_core_clk / nvdla_core_rstn : clock, async active-low reset
//     wr_pvld / wr_prdy / wr_pd        : write side handshake + payload
//     rd_pvld / rd_prdy / rd_pd        : read side handshake + payload
//     ram_wa / ram_we / ram_di         : RAM write port
//     ram_ra / ram_re / ram_ore        : RAM read address / enables
//     ram_byp_sel / ram_dbyp           : RAM bypass mux into the output reg
//     ram_dout                         : RAM registered read data
//     ram_count                        : entries currently held in the RAM
//
//   Build option
//     NV_FIFO_BYPASS_EN : when defined, a write into an empty, idle FIFO is
//     routed through the RAM bypass mux straight into the output register,
//     skipping the RAM. When undefined, every write goes through the RAM.

module nv_fifo_ctrl_19x32 #(
  parameter int DEPTH      = 19,
  parameter int WIDTH      = 32,
  parameter int AW         = 5,
  parameter int OBUF_DEPTH = 3
) (
  input  logic             nvdla_core_clk,
  input  logic             nvdla_core_rstn,
  input  logic             wr_pvld,
  output logic             wr_prdy,
  input  logic [WIDTH-1:0] wr_pd,
  output logic             rd_pvld,
  input  logic             rd_prdy,
  output logic [WIDTH-1:0] rd_pd,
  output logic [AW-1:0]    ram_wa,
  output logic             ram_we,
  output logic [WIDTH-1:0] ram_di,
  output logic [AW-1:0]    ram_ra,
  output logic             ram_re,
  output logic             ram_ore,
  output logic             ram_byp_sel,
  output logic [WIDTH-1:0] ram_dbyp,
  input  logic [WIDTH-1:0] ram_dout,
  output logic [AW-1:0]    ram_count
);

  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);
  localparam logic [AW-1:0] DEPTH_W  = AW'(DEPTH);
  localparam logic [2:0]    OBUF_LIM = 3'(OBUF_DEPTH);
  localparam logic [1:0]    OBUF_TOP = 2'(OBUF_DEPTH - 1);

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    ram_count_q, ram_count_d;
  logic             p1_vld_q, p1_vld_d;
  logic             p2_vld_q, p2_vld_d;
  logic [1:0]       obuf_cnt_q, obuf_cnt_d;
  logic [1:0]       obuf_rd_q, obuf_rd_d;
  logic [1:0]       obuf_wr_q, obuf_wr_d;
  logic [WIDTH-1:0] obuf_q [OBUF_DEPTH];
  logic [WIDTH-1:0] obuf_d [OBUF_DEPTH];

  logic       wr_acc;
  logic       pop;
  logic       rd_iss;
  logic       byp;
  logic [2:0] occ;
`ifdef NV_FIFO_BYPASS_EN
  logic [2:0] byp_occ;
`endif

  function automatic logic [1:0] obuf_inc(input logic [1:0] idx);
    return (idx == OBUF_TOP) ? 2'd0 : idx + 2'd1;
  endfunction

  // Handshake, read-issue credit and RAM control
  always_comb begin
    wr_prdy = (ram_count_q < DEPTH_W);
    rd_pvld = (obuf_cnt_q != 2'd0);
    rd_pd   = obuf_q[obuf_rd_q];
    wr_acc  = wr_pvld & wr_prdy;
    pop     = rd_pvld & rd_prdy;
    // Everything already heading for the output buffer must still fit
    // after this cycle's pop; this is what keeps obuf from overflowing.
    occ     = {1'b0, obuf_cnt_q} + {2'b0, p1_vld_q} + {2'b0, p2_vld_q};
    rd_iss  = (ram_count_q != '0) && (occ < OBUF_LIM + {2'b0, pop});
`ifdef NV_FIFO_BYPASS_EN
    // Bypass only when nothing older is in the RAM or stage 1, otherwise
    // the bypassed word could overtake it in the output register.
    byp_occ  = {1'b0, obuf_cnt_q} + {2'b0, p2_vld_q};
    byp      = wr_acc && (ram_count_q == '0) && !p1_vld_q && !rd_iss &&
               (byp_occ < OBUF_LIM + {2'b0, pop});
    ram_dbyp = wr_pd;
`else
    byp      = 1'b0;
    ram_dbyp = '0;
`endif
    ram_we      = wr_acc & ~byp;
    ram_wa      = wr_ptr_q;
    ram_di      = wr_pd;
    ram_re      = rd_iss;
    ram_ra      = rd_ptr_q;
    ram_ore     = p1_vld_q | byp;
    ram_byp_sel = byp;
    ram_count   = ram_count_q;
  end

  // Next-state
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    ram_count_d = ram_count_q;
    obuf_d      = obuf_q;
    obuf_wr_d   = obuf_wr_q;
    obuf_rd_d   = obuf_rd_q;
    obuf_cnt_d  = obuf_cnt_q;

    if (ram_we) wr_ptr_d = (wr_ptr_q == LAST_IDX) ? '0 : wr_ptr_q + 1'b1;
    if (rd_iss) rd_ptr_d = (rd_ptr_q == LAST_IDX) ? '0 : rd_ptr_q + 1'b1;

    case ({ram_we, rd_iss})
      2'b10:   ram_count_d = ram_count_q + 1'b1;
      2'b01:   ram_count_d = ram_count_q - 1'b1;
      default: ram_count_d = ram_count_q;
    endcase

    p1_vld_d = rd_iss;
    p2_vld_d = ram_ore;

    // p2_vld means the RAM output register holds a fresh word this cycle
    if (p2_vld_q) begin
      obuf_d[obuf_wr_q] = ram_dout;
      obuf_wr_d         = obuf_inc(obuf_wr_q);
    end
    if (pop) obuf_rd_d = obuf_inc(obuf_rd_q);

    case ({p2_vld_q, pop})
      2'b10:   obuf_cnt_d = obuf_cnt_q + 2'd1;
      2'b01:   obuf_cnt_d = obuf_cnt_q - 2'd1;
      default: obuf_cnt_d = obuf_cnt_q;
    endcase
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      ram_count_q <= '0;
      p1_vld_q    <= 1'b0;
      p2_vld_q    <= 1'b0;
      obuf_cnt_q  <= 2'd0;
      obuf_rd_q   <= 2'd0;
      obuf_wr_q   <= 2'd0;
      for (int i = 0; i < OBUF_DEPTH; i++) obuf_q[i] <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      ram_count_q <= ram_count_d;
      p1_vld_q    <= p1_vld_d;
      p2_vld_q    <= p2_vld_d;
      obuf_cnt_q  <= obuf_cnt_d;
      obuf_rd_q   <= obuf_rd_d;
      obuf_wr_q   <= obuf_wr_d;
      obuf_q      <= obuf_d;
    end
  end

endmodule

// File: tb/tb_nv_fifo_ctrl_19x32.sv
// Testbench for nv_fifo_ctrl_19x32 with a behavioural 19x32 RAM
// (two-stage registered read, bypass mux into the output register).

module tb_nv_fifo_ctrl_19x32;

  logic        clk;
  logic        rstn;
  logic        wr_pvld;
  logic        wr_prdy;
  logic [31:0] wr_pd;
  logic        rd_pvld;
  logic        rd_prdy;
  logic [31:0] rd_pd;
  logic [4:0]  ram_wa;
  logic        ram_we;
  logic [31:0] ram_di;
  logic [4:0]  ram_ra;
  logic        ram_re;
  logic        ram_ore;
  logic        ram_byp_sel;
  logic [31:0] ram_dbyp;
  logic [31:0] ram_dout;
  logic [4:0]  ram_count;

`ifdef NV_FIFO_BYPASS_EN
  localparam int EXP_LAT = 2;
`else
  localparam int EXP_LAT = 4;
`endif

  nv_fifo_ctrl_19x32 dut (
    .nvdla_core_clk (clk),
    .nvdla_core_rstn(rstn),
    .wr_pvld        (wr_pvld),
    .wr_prdy        (wr_prdy),
    .wr_pd          (wr_pd),
    .rd_pvld        (rd_pvld),
    .rd_prdy        (rd_prdy),
    .rd_pd          (rd_pd),
    .ram_wa         (ram_wa),
    .ram_we         (ram_we),
    .ram_di         (ram_di),
    .ram_ra         (ram_ra),
    .ram_re         (ram_re),
    .ram_ore        (ram_ore),
    .ram_byp_sel    (ram_byp_sel),
    .ram_dbyp       (ram_dbyp),
    .ram_dout       (ram_dout),
    .ram_count      (ram_count)
  );

  // RAM model
  logic [31:0] mem [0:31];
  logic [4:0]  ra_d;
  logic [31:0] dout_r;
  always @(posedge clk) begin
    if (ram_we) mem[ram_wa] <= ram_di;
    if (ram_re) ra_d <= ram_ra;
    if (ram_ore) dout_r <= ram_byp_sel ? ram_dbyp : mem[ra_d];
  end
  assign ram_dout = dout_r;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: FIFO order of accepted words, RAM occupancy, and the
  // address sequences the RAM ports must walk through.
  logic [31:0] expq[$];
  int exp_cnt = 0;
  int exp_wa  = 0;
  int exp_ra  = 0;
  int n_acc   = 0;
  int n_pop   = 0;

  // Advance one cycle; the per-cycle scoreboard runs at the falling edge.
  task automatic tick();
    logic        acc, pop;
    logic [31:0] e;
    int          inflight;
    @(negedge clk);
    if (!rstn) begin
      expq.delete();
      exp_cnt = 0; exp_wa = 0; exp_ra = 0; n_acc = 0; n_pop = 0;
    end else begin
      acc = wr_pvld && wr_prdy;
      pop = rd_pvld && rd_prdy;
      n_checks++;
      if (wr_prdy !== (exp_cnt < 19))
        $display("FAIL wr_prdy_rule: got %0b exp %0b (count %0d)", wr_prdy, exp_cnt < 19, exp_cnt);
      else n_pass++;
      n_checks++;
      if (ram_count !== 5'(exp_cnt))
        $display("FAIL ram_count_track: got %0d exp %0d", ram_count, exp_cnt);
      else n_pass++;
      inflight = n_acc - n_pop - int'(ram_count);
      n_checks++;
      if (inflight < 0 || inflight > 3)
        $display("FAIL obuf_bound: outside-RAM items %0d, allowed 0..3", inflight);
      else n_pass++;
`ifndef NV_FIFO_BYPASS_EN
      n_checks++;
      if (ram_we !== acc) $display("FAIL ram_we_rule: got %0b exp %0b", ram_we, acc);
      else n_pass++;
`endif
      if (ram_we) begin
        n_checks++;
        if (!acc || ram_wa !== 5'(exp_wa))
          $display("FAIL ram_write: acc %0b wa %0d exp %0d", acc, ram_wa, exp_wa);
        else n_pass++;
        exp_wa = (exp_wa == 18) ? 0 : exp_wa + 1;
      end
      if (ram_re) begin
        n_checks++;
        if (ram_count == 5'd0 || ram_ra !== 5'(exp_ra))
          $display("FAIL ram_read_issue: count %0d ra %0d exp ra %0d", ram_count, ram_ra, exp_ra);
        else n_pass++;
        exp_ra = (exp_ra == 18) ? 0 : exp_ra + 1;
      end
      if (acc) begin
        expq.push_back(wr_pd);
        n_acc++;
      end
      if (pop) begin
        n_checks++;
        if (expq.size() == 0) $display("FAIL rd_data: got %h exp none (queue empty)", rd_pd);
        else begin
          e = expq.pop_front();
          if (rd_pd !== e) $display("FAIL rd_data: got %h exp %h", rd_pd, e);
          else n_pass++;
        end
        n_pop++;
      end
      exp_cnt = exp_cnt + int'(ram_we) - int'(ram_re);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0; wr_pvld = 1'b0; rd_prdy = 1'b0; wr_pd = '0;
    repeat (3) tick();
    n_checks++;
    if (wr_prdy !== 1'b1 || rd_pvld !== 1'b0 || ram_count !== 5'd0)
      $display("FAIL reset_state: prdy %0b pvld %0b count %0d exp 1 0 0", wr_prdy, rd_pvld, ram_count);
    else n_pass++;
    n_checks++;
    if (ram_we !== 1'b0 || ram_re !== 1'b0 || ram_ore !== 1'b0 || ram_byp_sel !== 1'b0)
      $display("FAIL reset_ram_ctl: we %0b re %0b ore %0b byp %0b exp 0000", ram_we, ram_re, ram_ore, ram_byp_sel);
    else n_pass++;
    rstn = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_single();
    int lat;
    logic [31:0] got;
    lat = 0; got = '0;
    rd_prdy = 1'b1; wr_pvld = 1'b1; wr_pd = 32'hA5A5_0001;
    tick();
    wr_pvld = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      if (rd_pvld && lat == 0) begin lat = k; got = rd_pd; end
      tick();
    end
    n_checks++;
    if (lat !== EXP_LAT) $display("FAIL single_latency: got %0d exp %0d", lat, EXP_LAT);
    else n_pass++;
    n_checks++;
    if (got !== 32'hA5A5_0001) $display("FAIL single_data: got %h exp a5a50001", got);
    else n_pass++;
    n_checks++;
    if (ram_count !== 5'd0 || rd_pvld !== 1'b0)
      $display("FAIL single_idle: count %0d pvld %0b exp 0 0", ram_count, rd_pvld);
    else n_pass++;
  endtask

  task automatic test_fill();
    int n, got, bad;
    logic acc;
    n = 0;
    rd_prdy = 1'b0; wr_pvld = 1'b1;
    for (int c = 0; c < 200 && n < 22; c++) begin
      wr_pd = 32'(n);
      acc = wr_prdy;
      tick();
      if (acc) n++;
    end
    n_checks++;
    if (n !== 22) $display("FAIL fill_accepts: got %0d exp 22", n);
    else n_pass++;
    n_checks++;
    if (wr_prdy !== 1'b0) $display("FAIL fill_prdy_drop: got %0b exp 0", wr_prdy);
    else n_pass++;
    wr_pd = 32'hDEAD_BEEF;
    repeat (3) tick();
    wr_pvld = 1'b0;
    repeat (3) tick();
    n_checks++;
    if (ram_count !== 5'd19) $display("FAIL fill_count: got %0d exp 19", ram_count);
    else n_pass++;
    n_checks++;
    if (rd_pvld !== 1'b1 || rd_pd !== 32'd0)
      $display("FAIL fill_head: pvld %0b pd %h exp 1 00000000", rd_pvld, rd_pd);
    else n_pass++;
    got = 0; bad = 0;
    rd_prdy = 1'b1;
    for (int c = 0; c < 200 && got < 22; c++) begin
      if (rd_pvld) begin
        if (rd_pd !== 32'(got)) bad++;
        got++;
      end
      tick();
    end
    rd_prdy = 1'b0;
    n_checks++;
    if (got !== 22 || bad !== 0) $display("FAIL fill_drain: got %0d items %0d out of order, exp 22 0", got, bad);
    else n_pass++;
    n_checks++;
    if (ram_count !== 5'd0) $display("FAIL fill_drain_count: got %0d exp 0", ram_count);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int wi, recv, bubbles, stalls, bad;
    logic acc;
    wi = 0; recv = 0; bubbles = 0; stalls = 0; bad = 0;
    wr_pvld = 1'b1; rd_prdy = 1'b1;
    for (int c = 0; c < 300 && recv < 50; c++) begin
      wr_pvld = (wi < 50);
      wr_pd   = 32'h1000_0000 + 32'(wi);
      if (rd_pvld) begin
        if (rd_pd !== 32'h1000_0000 + 32'(recv)) bad++;
        recv++;
      end else if (recv > 0) bubbles++;
      if (wr_pvld && !wr_prdy) stalls++;
      acc = wr_pvld && wr_prdy;
      tick();
      if (acc) wi++;
    end
    wr_pvld = 1'b0; rd_prdy = 1'b0;
    n_checks++;
    if (recv !== 50 || bad !== 0) $display("FAIL stream_data: recv %0d bad %0d exp 50 0", recv, bad);
    else n_pass++;
    n_checks++;
    if (bubbles !== 0 || stalls !== 0) $display("FAIL stream_rate: bubbles %0d stalls %0d exp 0 0", bubbles, stalls);
    else n_pass++;
  endtask

  task automatic test_random();
    int sent, recv;
    logic acc, pop;
    sent = 0; recv = 0;
    void'($urandom(1));
    for (int c = 0; c < 5000 && recv < 200; c++) begin
      wr_pvld = (sent < 200) && ($urandom_range(0, 3) != 0);
      wr_pd   = $urandom;
      rd_prdy = ($urandom_range(0, 1) == 1);
      acc = wr_pvld && wr_prdy;
      pop = rd_pvld && rd_prdy;
      tick();
      if (acc) sent++;
      if (pop) recv++;
    end
    wr_pvld = 1'b0; rd_prdy = 1'b0;
    n_checks++;
    if (recv !== 200 || expq.size() !== 0)
      $display("FAIL random_total: recv %0d left %0d exp 200 0", recv, expq.size());
    else n_pass++;
  endtask

  task automatic test_simultaneous();
    int n, wa0, ra0;
    logic acc;
    n = 0;
    rd_prdy = 1'b0; wr_pvld = 1'b1;
    for (int c = 0; c < 100 && n < 13; c++) begin
      wr_pd = 32'h5000_0000 + 32'(n);
      acc = wr_prdy;
      tick();
      if (acc) n++;
    end
    wr_pvld = 1'b0;
    repeat (5) tick();
    n_checks++;
    if (ram_count !== 5'd10) $display("FAIL simul_setup: count %0d exp 10", ram_count);
    else n_pass++;
    wa0 = exp_wa; ra0 = exp_ra;
    wr_pvld = 1'b1; rd_prdy = 1'b1; wr_pd = 32'h5555_AAAA;
    #1;
    n_checks++;
    if (ram_we !== 1'b1 || ram_re !== 1'b1) $display("FAIL simul_both: we %0b re %0b exp 1 1", ram_we, ram_re);
    else n_pass++;
    tick();
    wr_pvld = 1'b0; rd_prdy = 1'b0;
    #1;
    n_checks++;
    if (ram_count !== 5'd10) $display("FAIL simul_count: got %0d exp 10", ram_count);
    else n_pass++;
    n_checks++;
    if (ram_wa !== 5'((wa0 + 1) % 19) || ram_ra !== 5'((ra0 + 1) % 19))
      $display("FAIL simul_ptrs: wa %0d ra %0d exp %0d %0d", ram_wa, ram_ra, (wa0 + 1) % 19, (ra0 + 1) % 19);
    else n_pass++;
    rd_prdy = 1'b1;
    for (int c = 0; c < 100 && (expq.size() != 0 || rd_pvld); c++) tick();
    rd_prdy = 1'b0;
    n_checks++;
    if (expq.size() !== 0 || ram_count !== 5'd0)
      $display("FAIL simul_drain: left %0d count %0d exp 0 0", expq.size(), ram_count);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int n, seen;
    logic acc;
    n = 0; seen = 0;
    rd_prdy = 1'b0; wr_pvld = 1'b1;
    for (int c = 0; c < 100 && n < 10; c++) begin
      wr_pd = 32'h7000_0000 + 32'(n);
      acc = wr_prdy;
      tick();
      if (acc) n++;
    end
    wr_pvld = 1'b0;
    repeat (5) tick();
    n_checks++;
    if (ram_count !== 5'd7) $display("FAIL rstmid_setup: count %0d exp 7", ram_count);
    else n_pass++;
    wr_pvld = 1'b1; rd_prdy = 1'b1; wr_pd = 32'h7777_7777;
    tick();
    rstn = 1'b0; wr_pvld = 1'b0;
    #1;
    n_checks++;
    if (rd_pvld !== 1'b0 || wr_prdy !== 1'b1 || ram_count !== 5'd0)
      $display("FAIL rstmid_async: pvld %0b prdy %0b count %0d exp 0 1 0", rd_pvld, wr_prdy, ram_count);
    else n_pass++;
    n_checks++;
    if (ram_we !== 1'b0 || ram_re !== 1'b0 || ram_ore !== 1'b0 || ram_byp_sel !== 1'b0)
      $display("FAIL rstmid_ram_ctl: we %0b re %0b ore %0b byp %0b exp 0000", ram_we, ram_re, ram_ore, ram_byp_sel);
    else n_pass++;
    repeat (2) tick();
    rstn = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (rd_pvld) seen++;
      tick();
    end
    n_checks++;
    if (seen !== 0 || wr_prdy !== 1'b1 || ram_count !== 5'd0)
      $display("FAIL rstmid_after: pvld cycles %0d prdy %0b count %0d exp 0 1 0", seen, wr_prdy, ram_count);
    else n_pass++;
    rd_prdy = 1'b0;
  endtask

  initial begin
    rstn = 1'b0; wr_pvld = 1'b0; rd_prdy = 1'b0; wr_pd = '0;
    #1;
    test_reset();
    test_single();
    test_fill();
    test_back_to_back();
    test_random();
    test_simultaneous();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/nv_fifo_ctrl_19x32.md
Name: nv_fifo_ctrl_19x32

Overview:
Valid/ready FIFO controller that drives the 19x32 FPGA RAM model (ports ra/re/ore/wa/we/di/byp_sel/dbyp/dout) as its storage. It converts the RAM's two-stage registered read into a streaming, backpressure-safe output. A 3-entry output buffer gives full throughput. Sits in the NVDLA datapath as the FIFO wrapper that every 19x32 RAM instance needs.

Parameters:
DEPTH, 19, RAM entries; must match the attached RAM.
WIDTH, 32, payload width; must match the RAM.
AW, 5, RAM address width.
OBUF_DEPTH, 3, output buffer entries; covers the 3-edge read loop.

Ports:
nvdla_core_clk  input  1  single clock; all state is posedge.
nvdla_core_rstn  input  1  asynchronous active-low reset.
wr_pvld  input  1  write valid.
wr_prdy  output  1  write ready.
wr_pd  input  WIDTH  write payload.
rd_pvld  output  1  read valid.
rd_prdy  input  1  read ready.
rd_pd  output  WIDTH  read payload, taken from the head of the output buffer.
ram_wa  output  AW  RAM write address.
ram_we  output  1  RAM write enable.
ram_di  output  WIDTH  RAM write data; equals wr_pd.
ram_ra  output  AW  RAM read address.
ram_re  output  1  RAM read enable.
ram_ore  output  1  RAM output-register enable.
ram_byp_sel  output  1  RAM bypass select.
ram_dbyp  output  WIDTH  RAM bypass data; equals wr_pd.
ram_dout  input  WIDTH  RAM registered read data.
ram_count  output  AW  number of entries held in the RAM, 0..19.

Behaviour:
- Reset (async assert, sync release):
  - wr_ptr, rd_ptr, ram_count, p1_vld, p2_vld and obuf_cnt are all 0.
  - Outputs: wr_prdy=1, rd_pvld=0, ram_we=0, ram_re=0, ram_ore=0, ram_byp_sel=0.
  - Data held in the RAM is discarded. Reset during a transfer drops all in-flight data with no partial output.
- Write side:
  - wr_prdy = (ram_count < 19). It is registered-state based and does not look ahead at same-cycle reads.
  - On accept (wr_pvld & wr_prdy): ram_we=1, ram_wa=wr_ptr; wr_ptr increments and wraps 18->0.
- Read issue:
  - Condition: ram_re = (ram_count > 0) & (obuf_cnt + p1_vld + p2_vld - pop < OBUF_DEPTH), where pop = rd_pvld & rd_prdy.
  - On issue: ram_ra=rd_ptr; rd_ptr wraps 18->0; p1_vld<=1 next cycle, else 0.
- Read pipeline:
  - ram_ore = p1_vld, so the RAM captures M[ra_d] at that edge.
  - p2_vld <= ram_ore.
  - When p2_vld=1, ram_dout is pushed into obuf at that edge.
- ram_count update: +1 on write accept, -1 on read issue, unchanged when both happen.
  - Both at count=19: impossible, since wr_prdy=0.
  - Write at count=0: no read is issued that cycle; the earliest issue is the next cycle.
- Latency, write accept edge to rd_pvld (no bypass):
  - 1 cycle to re, then edges for ra_d, dout_r and obuf.
  - rd_pvld rises 4 cycles after the wr_pvld&wr_prdy cycle.
- Throughput: 1 item/cycle sustained with rd_prdy=1.
- Output buffer: FIFO-ordered, 3 entries. rd_pvld = (obuf_cnt > 0). Push and pop in the same cycle leave obuf_cnt unchanged. The issue credit rule guarantees no overflow.
- Ordering: strict FIFO; data is never reordered.
- Idle: ram_byp_sel=0 whenever the bypass path below is not active.

Optional Feature:
Macro NV_FIFO_BYPASS_EN.
- Defined: bypass cycle when a write is accepted while ram_count==0, p1_vld==0, there is no read issue, and credit is available (obuf_cnt + p2_vld - pop < OBUF_DEPTH).
  - The write is not stored in the RAM: ram_we=0 and ram_count/wr_ptr are unchanged.
  - Drive ram_byp_sel=1, ram_ore=1; ram_dbyp=wr_pd is captured into dout_r.
  - p2_vld <= 1 next cycle.
  - Latency: rd_pvld 2 cycles after accept.
- Not defined: ram_byp_sel is tied 0, ram_dbyp is tied 0, and all writes go through the RAM.

Test Plan:
1. Reset, then write 0xA5A5_0001 once with rd_prdy=1 -> rd_pd=0xA5A5_0001. rd_pvld rises 4 cycles after accept, or 2 with NV_FIFO_BYPASS_EN; ram_count returns to 0.
2. rd_prdy=0, write 22 items (0..21) -> ram_count=19 with 3 in obuf. wr_prdy drops after the 22nd accept. rd_pvld=1 with rd_pd=0. After draining, output is 0..21 in order.
3. Continuous wr_pvld=rd_prdy=1 with 50 incrementing words -> after the fill latency, one output per cycle with no bubbles. Pointers wrap 18->0 twice and the data matches.
4. Random rd_prdy stall pattern (seed 1) with 200 items -> no loss or duplication; obuf_cnt never exceeds 3; ram_re is never asserted at ram_count=0.
5. Simultaneous write accept and read issue at ram_count=10 -> ram_count stays 10 and both pointers advance by 1.
6. Assert nvdla_core_rstn low mid-stream with ram_count=7 -> outputs go to reset values immediately. After release: rd_pvld=0, wr_prdy=1, ram_count=0.
